// File: rtl/gshare_bp_pkg.sv
// Shared definitions for the gshare/bimodal branch direction predictor.
// Holds counter-state constants, the FSM encoding and the index hash.
// Optional gshare indexing is selected by the CBP_GSHARE_EN macro.
package gshare_bp_pkg;

    // Counter states for the default 2-bit counter: 0, 1, 2, 3.
    localparam int DEF_CNT_W = 2;
    localparam int SNT = 0;
    localparam int WNT = (1 << (DEF_CNT_W - 1)) - 1;
    localparam int WT  = 1 << (DEF_CNT_W - 1);
    localparam int ST  = (1 << DEF_CNT_W) - 1;

    // Weakly-not-taken value for an arbitrary counter width.
    function automatic int cnt_wnt(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // Strongly-taken (saturation) value for an arbitrary counter width.
    function automatic int cnt_st(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // Table index: PC word-index bits XOR zero-extended history.
    function automatic logic [31:0] idx_hash(input logic [31:0] pc_idx,
                                             input logic [31:0] ghr);
        return pc_idx ^ ghr;
    endfunction

endpackage

// File: rtl/gshare_bp_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
// master = pipeline side driving requests and training, slave = predictor.
// No latency or backpressure of its own; ready_o gates acceptance.
interface gshare_bp_if #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int GHR_W = 6
);
    logic             ready_o;
    logic             pred_req_i;
    logic [PC_W-1:0]  pred_pc_i;
    logic             pred_valid_o;
    logic             pred_taken_o;
    logic [IDX_W-1:0] pred_idx_o;
    logic [GHR_W-1:0] pred_ghr_o;
    logic             train_valid_i;
    logic [IDX_W-1:0] train_idx_i;
    logic             train_taken_i;
    logic             train_mispredict_i;
    logic [GHR_W-1:0] train_ghr_i;

    modport master (
        input  ready_o, pred_valid_o, pred_taken_o, pred_idx_o, pred_ghr_o,
        output pred_req_i, pred_pc_i,
        output train_valid_i, train_idx_i, train_taken_i,
        output train_mispredict_i, train_ghr_i
    );

    modport slave (
        output ready_o, pred_valid_o, pred_taken_o, pred_idx_o, pred_ghr_o,
        input  pred_req_i, pred_pc_i,
        input  train_valid_i, train_idx_i, train_taken_i,
        input  train_mispredict_i, train_ghr_i
    );
endinterface

// File: rtl/gshare_bp_sat_counter_table.sv
// Array of 2^IDX_W saturating counters with sweep-init and train write port.
// Combinational read; writes land on the clock edge (read-before-write).
// No backpressure: sweep write has priority over training updates.
module sat_counter_table
    import gshare_bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             sweep_en,
    input  logic [IDX_W-1:0] sweep_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_wnt(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_st(CNT_W));

    logic [CNT_W-1:0] cnt_mem [2**IDX_W];
    logic [CNT_W-1:0] upd_cur;
    logic [CNT_W-1:0] upd_nxt;

    assign upd_cur = cnt_mem[upd_idx];
    assign rd_cnt  = cnt_mem[rd_idx];

    // Saturating increment/decrement of the trained counter.
    always_comb begin
        upd_nxt = upd_cur;
        if (upd_taken) begin
            if (upd_cur != CNT_MAX) upd_nxt = upd_cur + CNT_W'(1);
        end else begin
            if (upd_cur != '0) upd_nxt = upd_cur - CNT_W'(1);
        end
    end

    // Single write port: init sweep first, otherwise training.
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            cnt_mem[sweep_idx] <= CNT_INIT;
        end else if (upd_en) begin
            cnt_mem[upd_idx] <= upd_nxt;
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// Conditional-branch direction predictor; gshare when CBP_GSHARE_EN, else bimodal.
// Latency: prediction registered 1 cycle after request; training visible next cycle.
// Backpressure: ready_o low during the init sweep; mispredict drops a same-cycle request.
module gshare_bp
    import gshare_bp_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2,
    parameter int GHR_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    gshare_bp_if.slave  bp
);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             sweep_en;
    logic             run;

    logic [PC_W-1:0]  pc_w;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] rd_cnt;
    logic             pred_tk;
    logic             train_en;
    logic             accept;
    logic [GHR_W-1:0] ghr_snap;

    logic             valid_q;
    logic             taken_q;
    logic [IDX_W-1:0] idx_q;
    logic [GHR_W-1:0] ghr_out_q;

    // FSM state and sweep pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Sweep one entry per cycle in INIT, then stay in RUN.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        sweep_en = 1'b0;
        case (state_q)
            INIT: begin
                sweep_en = 1'b1;
                sweep_d  = sweep_q + IDX_W'(1);
                if (sweep_q == LAST_IDX) state_d = RUN;
            end
            RUN: begin
                state_d = RUN;
            end
            default: state_d = INIT;
        endcase
    end

    assign run      = (state_q == RUN);
    assign pc_w     = bp.pred_pc_i;
    assign pc_idx   = pc_w[IDX_W+1:2];
    assign pred_tk  = rd_cnt[CNT_W-1];
    assign train_en = run && bp.train_valid_i;

    logic unused_pc;
    assign unused_pc = ^pc_w;

`ifdef CBP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic             flush;

    assign flush    = train_en && bp.train_mispredict_i;
    assign accept   = run && bp.pred_req_i && !flush;
    assign rd_idx   = IDX_W'(idx_hash(32'(pc_idx), 32'(ghr_q)));
    assign ghr_snap = ghr_q;

    // History: mispredict recovery outranks the speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (flush) begin
            ghr_q <= GHR_W'({bp.train_ghr_i, bp.train_taken_i});
        end else if (accept) begin
            ghr_q <= GHR_W'({ghr_q, pred_tk});
        end
    end
`else
    logic unused_train;

    assign accept       = run && bp.pred_req_i;
    assign rd_idx       = pc_idx;
    assign ghr_snap     = '0;
    assign unused_train = ^{bp.train_ghr_i, bp.train_mispredict_i};
`endif

    sat_counter_table #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_table (
        .clk       (clk),
        .sweep_en  (sweep_en),
        .sweep_idx (sweep_q),
        .rd_idx    (rd_idx),
        .rd_cnt    (rd_cnt),
        .upd_en    (train_en),
        .upd_idx   (bp.train_idx_i),
        .upd_taken (bp.train_taken_i)
    );

    // Registered prediction outputs; fields hold between predictions.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            taken_q   <= 1'b0;
            idx_q     <= '0;
            ghr_out_q <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                taken_q   <= pred_tk;
                idx_q     <= rd_idx;
                ghr_out_q <= ghr_snap;
            end
        end
    end

    assign bp.ready_o      = run;
    assign bp.pred_valid_o = valid_q;
    assign bp.pred_taken_o = taken_q;
    assign bp.pred_idx_o   = idx_q;
    assign bp.pred_ghr_o   = ghr_out_q;

endmodule

// File: tb/tb_gshare_bp.sv
// Directed self-checking bench for gshare_bp (both CBP_GSHARE_EN builds).
// Inputs driven 1 time unit after the rising edge; outputs sampled there.
// Expected values are hand-derived; a small GHR model tracks history.
module tb_gshare_bp;
`ifdef CBP_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [5:0] ghr_m;

    gshare_bp_if #(.PC_W(32), .IDX_W(6), .GHR_W(6)) bp ();

    gshare_bp #(.PC_W(32), .IDX_W(6), .CNT_W(2), .GHR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_train();
        bp.train_valid_i      = 1'b0;
        bp.train_mispredict_i = 1'b0;
        bp.train_taken_i      = 1'b0;
        bp.train_idx_i        = '0;
        bp.train_ghr_i        = '0;
    endtask

    task automatic train(input logic [5:0] idx, input logic tk);
        bp.train_valid_i = 1'b1;
        bp.train_idx_i   = idx;
        bp.train_taken_i = tk;
        tick();
        clear_train();
    endtask

    task automatic mispredict(input logic [5:0] idx, input logic tk, input logic [5:0] ghr);
        bp.train_valid_i      = 1'b1;
        bp.train_idx_i        = idx;
        bp.train_taken_i      = tk;
        bp.train_mispredict_i = 1'b1;
        bp.train_ghr_i        = ghr;
        tick();
        clear_train();
    endtask

    // One-cycle request; any train signals set by the caller share the cycle.
    task automatic pred_pc(input string tag, input logic [31:0] pc, input logic exp_tk,
                           input logic [5:0] exp_idx, input logic [5:0] exp_ghr);
        bp.pred_req_i = 1'b1;
        bp.pred_pc_i  = pc;
        tick();
        bp.pred_req_i = 1'b0;
        clear_train();
        chk({tag, ".vld"},   32'(bp.pred_valid_o), 32'd1);
        chk({tag, ".taken"}, 32'(bp.pred_taken_o), 32'(exp_tk));
        chk({tag, ".idx"},   32'(bp.pred_idx_o),   32'(exp_idx));
        chk({tag, ".ghr"},   32'(bp.pred_ghr_o),   32'(exp_ghr));
    endtask

    // Predict a given table index, choosing the PC from the modelled GHR.
    task automatic predict_idx(input string tag, input logic [5:0] idx, input logic exp_tk);
        logic [5:0] h;
        h = GS ? (idx ^ ghr_m) : idx;
        pred_pc(tag, {24'd0, h, 2'b00}, exp_tk, idx, GS ? ghr_m : 6'd0);
        if (GS) ghr_m = {ghr_m[4:0], exp_tk};
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ghr_m    = '0;
        rst      = 1'b1;
        bp.pred_req_i = 1'b1;
        bp.pred_pc_i  = '0;
        clear_train();

        // Reset values with a request held.
        repeat (3) tick();
        chk("rst.ready", 32'(bp.ready_o),      32'd0);
        chk("rst.vld",   32'(bp.pred_valid_o), 32'd0);
        chk("rst.taken", 32'(bp.pred_taken_o), 32'd0);
        chk("rst.idx",   32'(bp.pred_idx_o),   32'd0);
        chk("rst.ghr",   32'(bp.pred_ghr_o),   32'd0);

        // Init sweep: ready after exactly 64 cycles, no predictions meanwhile.
        rst = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            chk("sweep.ready", 32'(bp.ready_o),      (i == 64) ? 32'd1 : 32'd0);
            chk("sweep.vld",   32'(bp.pred_valid_o), 32'd0);
        end
        bp.pred_req_i = 1'b0;

        // Fresh table predicts not-taken.
        predict_idx("first10", 6'd10, 1'b0);
        predict_idx("first20", 6'd20, 1'b0);

        // Saturation at index 5.
        repeat (4) train(6'd5, 1'b1);
        predict_idx("sat.st", 6'd5, 1'b1);
        train(6'd5, 1'b0);
        predict_idx("sat.wt", 6'd5, 1'b1);
        repeat (3) train(6'd5, 1'b0);
        predict_idx("sat.snt", 6'd5, 1'b0);
        train(6'd5, 1'b0);
        train(6'd5, 1'b1);
        predict_idx("sat.floor", 6'd5, 1'b0);

        // History shift on back-to-back predictions of PC 0x100.
        train(6'd0, 1'b1);
        mispredict(6'd63, 1'b0, 6'd0);
        pred_pc("gs1", 32'h100, 1'b1, 6'h00, 6'h00);
        pred_pc("gs2", 32'h100, GS ? 1'b0 : 1'b1, GS ? 6'h01 : 6'h00, GS ? 6'h01 : 6'h00);
        tick();
        chk("gs.vld_drop", 32'(bp.pred_valid_o), 32'd0);

        // Recovery: GHR to 0x2A, then mispredict with a same-cycle request.
        mispredict(6'd63, 1'b0, 6'h15);
        bp.train_valid_i      = 1'b1;
        bp.train_idx_i        = 6'd62;
        bp.train_taken_i      = 1'b1;
        bp.train_mispredict_i = 1'b1;
        bp.train_ghr_i        = 6'h15;
        bp.pred_req_i         = 1'b1;
        bp.pred_pc_i          = 32'h100;
        tick();
        bp.pred_req_i = 1'b0;
        clear_train();
        chk("rec.drop_vld", 32'(bp.pred_valid_o), GS ? 32'd0 : 32'd1);
        if (!GS) begin
            chk("rec.bim_idx",   32'(bp.pred_idx_o),   32'd0);
            chk("rec.bim_taken", 32'(bp.pred_taken_o), 32'd1);
        end
        pred_pc("rec", 32'h100, GS ? 1'b0 : 1'b1, GS ? 6'h2B : 6'h00, GS ? 6'h2B : 6'h00);
        ghr_m = GS ? 6'h16 : 6'h00;

        // Same-index predict and train: read returns the pre-update counter.
        bp.train_valid_i = 1'b1;
        bp.train_idx_i   = 6'd3;
        bp.train_taken_i = 1'b1;
        predict_idx("col.same", 6'd3, 1'b0);
        predict_idx("col.next", 6'd3, 1'b1);

        // PC 0x104: bimodal index 1 with zero history; gshare hashes it.
        pred_pc("pc104", 32'h104, 1'b0, GS ? (6'h01 ^ ghr_m) : 6'h01, GS ? ghr_m : 6'h00);

        // Reset mid-operation re-sweeps the table and clears history.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.ready", 32'(bp.ready_o),      32'd0);
        chk("rst2.vld",   32'(bp.pred_valid_o), 32'd0);
        repeat (64) tick();
        chk("rst2.ready_up", 32'(bp.ready_o), 32'd1);
        ghr_m = '0;
        predict_idx("rst2.idx0", 6'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
